// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks.
// Holds the slice width and the sequencing state encoding.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead adder with carry-in.
// Also exposes the carry into bit 3 so the caller can derive signed overflow.
module cla_nibble_slice
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout,
  output logic                o_c3
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[NIBBLE_W-1:0];
  assign o_cout = w_c[4];
  assign o_c3   = w_c[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one CLA nibble per clock, LSB first.
// Operands shift right through the single slice; results shift in from the top.
module nibble_serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = nib_count(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  sub_state_t          r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_nb;
  logic                r_carry;
  logic [KW-1:0]       r_k;
  logic [WIDTH-1:0]    r_diff;
  logic                r_bout;
  logic                r_ovf;
  logic                r_zero;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_c3;
  logic [WIDTH-1:0]    w_diff_next;

  cla_nibble_slice u_slice (
    .i_a    (r_a[NIBBLE_W-1:0]),
    .i_b    (r_nb[NIBBLE_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  // After N shifts the first nibble written has reached bit 0.
  generate
    if (N == 1) begin : g_single
      assign w_diff_next = w_sum;
    end else begin : g_multi
      assign w_diff_next = {w_sum, r_diff[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_nb        <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_nb       <= ~b;
            r_carry    <= ~bin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_a     <= r_a >> NIBBLE_W;
          r_nb    <= r_nb >> NIBBLE_W;
          r_diff  <= w_diff_next;
          r_carry <= w_cout;
          r_k     <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            // Subtraction via add: no carry out means a borrow occurred.
            r_bout      <= ~w_cout;
            r_ovf       <= w_c3 ^ w_cout;
            r_zero      <= (w_diff_next == '0);
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH 16) with hand-computed results.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_tests;
  int n_fail;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Accept one operation, scramble the inputs, wait for out_valid (bounded).
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       output int lat);
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; bin = ~vbin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_deliver", out_valid, 0);
    chk("in_ready_after_deliver", in_ready, 1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vbin;
    logic [15:0] ediff;
    logic        ebout;
    logic        eovf;
    logic        ezero;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    vecs.push_back('{"basic",      16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"underflow",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"neg_ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"zero",       16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"bin_ripple", 16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"bin_only",   16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"pos_ovf",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0});

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat);
      chk({vecs[i].name, "_lat"}, lat, 4);
      chk({vecs[i].name, "_in_ready"}, in_ready, 0);
      chk({vecs[i].name, "_diff"}, diff, vecs[i].ediff);
      chk({vecs[i].name, "_bout"}, bout, vecs[i].ebout);
      chk({vecs[i].name, "_ovf"}, ovf, vecs[i].eovf);
      chk({vecs[i].name, "_zero"}, zero, vecs[i].ezero);
      deliver();
    end

    // Backpressure: hold DONE for 5 cycles while upstream offers new operands.
    issue(16'h0100, 16'h0001, 1'b0, lat);
    chk("bp_lat", lat, 4);
    a = 16'h0009; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 16'h00FF);
      chk("bp_bout", bout, 0);
    end
    in_valid = 1'b0;
    deliver();
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_ghost_op", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);

    // Reset while nibble 2 is in the slice.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_flags", {bout, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_result", out_valid, 0);
    issue(16'h0003, 16'h0001, 1'b0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_diff", diff, 16'h0002);
    chk("post_rst_bout", bout, 0);
    deliver();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
